ladybird_interrupt_controller: RTL

Arbitrates up to N_SOURCES level-sensitive interrupt requests onto the core's single interrupt input. It replaces the top-level OR of the GPIO pending vector and the broadcast of the core's complete pulse. It adds per-source enables, fixed-priority or round-robin selection, and a claim/complete handshake that routes completion back to exactly one source. Software reaches it through a memory-mapped register slave on the peripheral bus.

---
 rtl/ladybird_interrupt_controller.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ladybird_interrupt_controller.sv
// ladybird_interrupt_controller
// Collects level-sensitive requests from up to N_SOURCES peripherals and
// drives one irq into the core. Selection is fixed-priority or round-robin.
// A claim/complete handshake routes the completion back to exactly one source.
// Software reaches the block through a four-word register slave:
//   0 ENABLE  1 PENDING  2 CLAIM  3 CONFIG
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no source in service; irq follows any eligible source
// CLAIMED | one source claimed by software; irq held low until completion

module ladybird_interrupt_controller #(
  parameter int N_SOURCES  = 8,
  parameter bit RR_DEFAULT = 1'b0
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [N_SOURCES-1:0] src_pending,
  output logic [N_SOURCES-1:0] src_complete,
  output logic                 irq,
  input  logic                 core_complete,
  input  logic                 bus_valid,
  input  logic                 bus_we,
  input  logic [3:0]           bus_addr,
  input  logic [31:0]          bus_wdata,
  output logic                 bus_ready,
  output logic [31:0]          bus_rdata
);

  typedef enum logic {
    IDLE    = 1'b0,
    CLAIMED = 1'b1
  } state_t;

  localparam logic [4:0] LAST_ID_RST = 5'(N_SOURCES - 1);

  localparam logic [1:0] REG_ENABLE  = 2'd0;
  localparam logic [1:0] REG_PENDING = 2'd1;
  localparam logic [1:0] REG_CLAIM   = 2'd2;

  state_t                 state_q, state_d;
  logic [N_SOURCES-1:0]   enable_q;
  logic                   rr_q;
  logic [N_SOURCES-1:0]   pend_q;
  logic [4:0]             last_id_q;
  logic [4:0]             svc_id_q;
  logic                   irq_q;
  logic [N_SOURCES-1:0]   src_complete_q;
  logic                   ready_q;
  logic [31:0]            rdata_q;

  logic                   accept;
  logic                   rd_acc;
  logic                   wr_acc;
  logic [1:0]             reg_idx;
  logic [N_SOURCES-1:0]   eligible;
  logic [31:0]            elig_ext;
  logic [4:0]             start_id;
  logic [5:0]             cand;
  logic                   sel_found;
  logic [4:0]             sel_id;
  logic                   claim_rd;
  logic                   wr_match;
  logic                   claim_go;
  logic                   done_go;
  logic [31:0]            rdata_d;
  logic [31:0]            svc_onehot;
  logic                   unused_bits;

  // A new access is only taken when no response is in flight, which gives
  // the one-access-per-two-cycles rate and ignores a valid still high in
  // the ready cycle.
  assign accept   = bus_valid && !ready_q;
  assign rd_acc   = accept && !bus_we;
  assign wr_acc   = accept && bus_we;
  assign reg_idx  = bus_addr[3:2];
  assign eligible = pend_q & enable_q;
  assign elig_ext = 32'(eligible);

  assign claim_rd = rd_acc && (reg_idx == REG_CLAIM) && sel_found;
  assign wr_match = wr_acc && (reg_idx == REG_CLAIM) &&
                    (bus_wdata[4:0] == (svc_id_q + 5'd1));

  assign svc_onehot  = 32'd1 << svc_id_q;
  assign unused_bits = ^{bus_addr[1:0], bus_wdata, svc_onehot};

  // Winner search: walk N_SOURCES candidates from start_id, wrapping, and
  // keep the first eligible one. Fixed priority simply starts at index 0.
  always_comb begin
    if (!rr_q || (last_id_q == LAST_ID_RST)) begin
      start_id = '0;
    end else begin
      start_id = last_id_q + 5'd1;
    end
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int i = 0; i < N_SOURCES; i++) begin
      cand = {1'b0, start_id} + 6'(i);
      if (cand >= 6'(N_SOURCES)) begin
        cand = cand - 6'(N_SOURCES);
      end
      if (!sel_found && elig_ext[cand[4:0]]) begin
        sel_found = 1'b1;
        sel_id    = cand[4:0];
      end
    end
  end

  // Claim/complete state machine: next state and the claim/done strobes.
  always_comb begin
    state_d  = state_q;
    claim_go = 1'b0;
    done_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (claim_rd) begin
          state_d  = CLAIMED;
          claim_go = 1'b1;
        end
      end
      CLAIMED: begin
        // A matching write and core_complete together still complete once.
        if (wr_match || core_complete) begin
          state_d = IDLE;
          done_go = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data mux; zero for writes and for idle cycles.
  always_comb begin
    rdata_d = '0;
    if (rd_acc) begin
      case (reg_idx)
        REG_ENABLE:  rdata_d = 32'(enable_q);
        REG_PENDING: rdata_d = 32'(eligible);
        REG_CLAIM:   rdata_d = claim_go ? (32'(sel_id) + 32'd1) : 32'd0;
        default:     rdata_d = {31'b0, rr_q};
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Software-writable configuration, updated at the accept edge.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      enable_q <= '0;
      rr_q     <= RR_DEFAULT;
    end else if (wr_acc) begin
      if (reg_idx == REG_ENABLE) begin
        enable_q <= bus_wdata[N_SOURCES-1:0];
      end else if (reg_idx == 2'd3) begin
        rr_q <= bus_wdata[0];
      end
    end
  end

  // Request capture stage.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      pend_q <= '0;
    end else begin
      pend_q <= src_pending;
    end
  end

  // In-service id and round-robin pointer, both updated on a claim.
  // The pointer resets to the top index so the first rr grant favours 0.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      svc_id_q  <= '0;
      last_id_q <= LAST_ID_RST;
    end else if (claim_go) begin
      svc_id_q  <= sel_id;
      last_id_q <= sel_id;
    end
  end

  // Registered outputs: irq, completion pulse and bus response.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      irq_q          <= 1'b0;
      src_complete_q <= '0;
      ready_q        <= 1'b0;
      rdata_q        <= '0;
    end else begin
      irq_q          <= (state_q == IDLE) && (|eligible);
      src_complete_q <= done_go ? svc_onehot[N_SOURCES-1:0] : '0;
      ready_q        <= accept;
      rdata_q        <= rdata_d;
    end
  end

  assign irq          = irq_q;
  assign src_complete = src_complete_q;
  assign bus_ready    = ready_q;
  assign bus_rdata    = rdata_q;

endmodule
